// File: rtl/aes_encrypt_iter_if.sv
// aes_encrypt_iter_if: plaintext/ciphertext handshake bus plus round-key input
interface aes_encrypt_iter_if;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;
    logic [1407:0]  round_keys_flat;
    modport master (
        output in_valid, in_data, out_ready, round_keys_flat,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, out_ready, round_keys_flat,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryptor, one round per clock, plus sbox and key_expansion
module sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign o_s = SBOX[i_a];
endmodule

module key_expansion (
    input  logic [127:0]  i_key,
    output logic [1407:0] o_round_keys_flat
);
    localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (genvar r = 0; r <= 10; r++) begin : g_r
        logic [127:0] w_k;
        if (r == 0) begin : g_first
            assign w_k = i_key;
        end else begin : g_next
            logic [31:0] w_rot, w_sub, w_n0, w_n1, w_n2, w_n3;
            assign w_rot = {g_r[r-1].w_k[23:0], g_r[r-1].w_k[31:24]};
            for (genvar b = 0; b < 4; b++) begin : g_b
                sbox u_sbox (.i_a(w_rot[8*b +: 8]), .o_s(w_sub[8*b +: 8]));
            end
            assign w_n0 = g_r[r-1].w_k[127:96] ^ w_sub ^ {RCON[r], 24'd0};
            assign w_n1 = g_r[r-1].w_k[95:64] ^ w_n0;
            assign w_n2 = g_r[r-1].w_k[63:32] ^ w_n1;
            assign w_n3 = g_r[r-1].w_k[31:0] ^ w_n2;
            assign w_k = {w_n0, w_n1, w_n2, w_n3};
        end
        assign o_round_keys_flat[128*r +: 128] = w_k;
    end
endmodule

module aes_encrypt_iter (
    input logic               clk,
    input logic               rst_n,
    aes_encrypt_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;
    state_t       r_state, w_next;
    logic [3:0]   r_cnt;
    logic [127:0] r_data, w_sb, w_sr, w_mc, w_key, w_round;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes then ShiftRows: output byte (col c, row r) takes input byte (col c+r, row r)
    for (genvar i = 0; i < 16; i++) begin : g_byte
        sbox u_sbox (.i_a(r_data[127-8*i -: 8]), .o_s(w_sb[127-8*i -: 8]));
        assign w_sr[127-8*i -: 8] = w_sb[127-8*(4*((i/4 + i%4) % 4) + i%4) -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign {w_a0, w_a1, w_a2, w_a3} = w_sr[127-32*c -: 32];
        assign w_mc[127-32*c -: 32] = {
            xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
            w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3,
            w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3,
            xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3)
        };
    end

    assign w_key         = bus.round_keys_flat[{r_cnt, 7'd0} +: 128];
    assign w_round       = (r_cnt == 4'd10 ? w_sr : w_mc) ^ w_key;
    assign bus.out_data  = r_data;

    // State register; reset wins over every transition
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake outputs decoded from the state
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) w_next = ROUND;
            end
            ROUND:   if (r_cnt == 4'd10) w_next = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: initial whitening on accept, one round per ROUND cycle, counter saturates at 10
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 4'd0;
            r_data <= 128'd0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_cnt  <= 4'd1;
            r_data <= bus.in_data ^ bus.round_keys_flat[127:0];
        end else if (r_state == ROUND) begin
            r_cnt  <= (r_cnt == 4'd10) ? r_cnt : r_cnt + 4'd1;
            r_data <= w_round;
        end
    end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: directed FIPS-197 vectors, backpressure, back-to-back and mid-round reset
module tb_aes_encrypt_iter;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [1407:0] REF_C1 = {
        128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        KEY_C1
    };
    localparam logic [1407:0] REF_B = {
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
        128'head27321b58dbad2312bf5607f8d292f, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hf2c295f27a96b9435935807a7359f67f, 128'ha0fafe1788542cb123a339392a6c7605,
        KEY_B
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  r_key;
    logic          use_ref;
    logic [1407:0] w_kx, w_ref;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt_iter_if bus ();
    key_expansion u_kx (.i_key(r_key), .o_round_keys_flat(w_kx));
    assign w_ref = (r_key == KEY_C1) ? REF_C1 : REF_B;
    assign bus.round_keys_flat = use_ref ? w_ref : w_kx;
    aes_encrypt_iter u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic enc(input string tag, input logic [127:0] pt, input logic [127:0] ct);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        bus.in_data  = pt;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 128'(bus.busy), 128'd1);
        chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            bus.in_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'd10);
        chk({tag, "_ct"}, bus.out_data, ct);
    endtask

    initial begin
        int n, stable, t_prev, t_acc;
        rst_n         = 1'b0;
        use_ref       = 1'b0;
        r_key         = KEY_C1;
        bus.in_valid  = 1'b1;
        bus.in_data   = PT_C1;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_out_data", bus.out_data, 128'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("rst_no_accept", 128'(bus.busy), 128'd0);

        for (int r = 0; r <= 10; r++) chk($sformatf("kx_c1_r%0d", r), w_kx[128*r +: 128], REF_C1[128*r +: 128]);
        r_key = KEY_B;
        #1;
        for (int r = 0; r <= 10; r++) chk($sformatf("kx_b_r%0d", r), w_kx[128*r +: 128], REF_B[128*r +: 128]);

        r_key = KEY_C1;
        enc("c1", PT_C1, CT_C1);
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            tick();
            if (!bus.out_valid || bus.out_data !== CT_C1 || bus.in_ready) stable = 0;
        end
        bus.in_valid = 1'b0;
        chk("bp_stable", 128'(stable), 128'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);

        r_key = KEY_B;
        enc("appb", PT_B, CT_B);
        tick();

        bus.in_valid = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.in_ready && n < 20) begin tick(); n++; end
            r_key       = k[0] ? KEY_B : KEY_C1;
            bus.in_data = k[0] ? PT_B : PT_C1;
            tick();
            t_acc = cyc;
            if (k > 0) chk($sformatf("b2b_spacing%0d", k), 128'(t_acc - t_prev), 128'd12);
            t_prev = t_acc;
            n = 0;
            while (!bus.out_valid && n < 20) begin
                bus.in_data = {$urandom, $urandom, $urandom, $urandom};
                tick();
                n++;
            end
            chk($sformatf("b2b_latency%0d", k), 128'(n), 128'd10);
            chk($sformatf("b2b_ct%0d", k), bus.out_data, k[0] ? CT_B : CT_C1);
        end
        bus.in_valid = 1'b0;
        tick();

        r_key        = KEY_C1;
        bus.in_data  = PT_C1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_out_data", bus.out_data, 128'd0);
        stable = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid || bus.busy) stable = 0;
        end
        chk("midrst_no_valid", 128'(stable), 128'd1);

        use_ref = 1'b1;
        enc("ref_c1", PT_C1, CT_C1);
        tick();
        r_key = KEY_B;
        enc("ref_b", PT_B, CT_B);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
